// File: rtl/crop_bbox_detect_pkg.sv
// crop_bbox_detect_pkg: shared defaults, FSM state type and bounding-box record for the crop bbox finder
package crop_bbox_detect_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_DATA_W   = 10;
    localparam int DEF_CNT_W    = 20;
    localparam int COORD_W      = 16;
    typedef enum logic [1:0] {WAIT_SOF, ACCUM, PUBLISH} stateT;
    typedef struct packed {
        logic [COORD_W-1:0] xMin;
        logic [COORD_W-1:0] xMax;
        logic [COORD_W-1:0] yMin;
        logic [COORD_W-1:0] yMax;
    } bboxT;
    // An empty box: any real pixel shrinks the mins and grows the maxes
    localparam bboxT BBOX_CLR = '{xMin: '1, xMax: '0, yMin: '1, yMax: '0};
endpackage

// File: rtl/crop_bbox_detect_if.sv
// crop_bbox_detect_if: pixel stream, frame config and bbox result bundle
//   master drives iSOF/iDVAL/iDATA/iTHRESH/iROI_*, slave drives oXSTART/oXEND/oYSTART/oYEND/oCOUNT/oFOUND/oVALID
interface crop_bbox_detect_if
    import crop_bbox_detect_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic               iSOF;
    logic               iDVAL;
    logic [DATA_W-1:0]  iDATA;
    logic [DATA_W-1:0]  iTHRESH;
    logic [COORD_W-1:0] iROI_X0;
    logic [COORD_W-1:0] iROI_X1;
    logic [COORD_W-1:0] iROI_Y0;
    logic [COORD_W-1:0] iROI_Y1;
    logic [COORD_W-1:0] oXSTART;
    logic [COORD_W-1:0] oXEND;
    logic [COORD_W-1:0] oYSTART;
    logic [COORD_W-1:0] oYEND;
    logic [CNT_W-1:0]   oCOUNT;
    logic               oFOUND;
    logic               oVALID;
    modport master (
        output iSOF, iDVAL, iDATA, iTHRESH, iROI_X0, iROI_X1, iROI_Y0, iROI_Y1,
        input  oXSTART, oXEND, oYSTART, oYEND, oCOUNT, oFOUND, oVALID
    );
    modport slave (
        input  iSOF, iDVAL, iDATA, iTHRESH, iROI_X0, iROI_X1, iROI_Y0, iROI_Y1,
        output oXSTART, oXEND, oYSTART, oYEND, oCOUNT, oFOUND, oVALID
    );
endinterface

// File: rtl/crop_bbox_detect_raster_cnt.sv
// crop_bbox_detect_raster_cnt: raster X/Y position of the current pixel
//   iCLK, iRST (sync, active-low), iCLR restarts at (0,0) this cycle, iINC advances past the current pixel
//   oX/oY position of the current pixel, oLAST current pixel is the final one of the frame and is accepted
module crop_bbox_detect_raster_cnt
    import crop_bbox_detect_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCLR,
    input  logic               iINC,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic               oLAST
);
    logic [COORD_W-1:0] x, y;
    logic endX, endY;
    // A clear seen together with a pixel makes that pixel (0,0)
    assign oX    = iCLR ? '0 : x;
    assign oY    = iCLR ? '0 : y;
    assign endX  = oX == COORD_W'(H_ACTIVE - 1);
    assign endY  = oY == COORD_W'(V_ACTIVE - 1);
    assign oLAST = iINC && endX && endY;
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            x <= '0;
            y <= '0;
        end else if (iINC) begin
            x <= endX ? '0 : oX + 1'b1;
            y <= endX ? (endY ? '0 : oY + 1'b1) : oY;
        end else if (iCLR) begin
            x <= '0;
            y <= '0;
        end
    end
endmodule

// File: rtl/crop_bbox_detect.sv
// crop_bbox_detect: per-frame bounding box and count of thresholded object pixels inside a runtime ROI
//   iCLK, iRST (sync, active-low); bus.slave carries the pixel stream, per-frame config and the published box
module crop_bbox_detect
    import crop_bbox_detect_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int POLARITY = 0
) (
    input logic                iCLK,
    input logic                iRST,
    crop_bbox_detect_if.slave  bus
);
    stateT              state;
    logic [DATA_W-1:0]  thrSh, thr;
    logic [COORD_W-1:0] x0Sh, x1Sh, y0Sh, y1Sh, x0, x1, y0, y1, pixX, pixY;
    logic               accept, last, isObj, hit, nxtFound;
    bboxT               acc, base, nxt;
    logic [CNT_W-1:0]   cnt, baseCnt, nxtCnt;
    // A SOF pixel is taken in any state; otherwise pixels only count mid-frame
    assign accept = bus.iDVAL && (bus.iSOF || state == ACCUM);
    crop_bbox_detect_raster_cnt #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) rasterCnt (
        .iCLK (iCLK),
        .iRST (iRST),
        .iCLR (bus.iSOF),
        .iINC (accept),
        .oX   (pixX),
        .oY   (pixY),
        .oLAST(last)
    );
    // On SOF the pixel is judged against the freshly presented config and an empty accumulator
    always_comb begin
        thr      = bus.iSOF ? bus.iTHRESH : thrSh;
        x0       = bus.iSOF ? bus.iROI_X0 : x0Sh;
        x1       = bus.iSOF ? bus.iROI_X1 : x1Sh;
        y0       = bus.iSOF ? bus.iROI_Y0 : y0Sh;
        y1       = bus.iSOF ? bus.iROI_Y1 : y1Sh;
        base     = bus.iSOF ? BBOX_CLR : acc;
        baseCnt  = bus.iSOF ? '0 : cnt;
        isObj    = (POLARITY != 0) ? bus.iDATA >= thr : bus.iDATA <= thr;
        hit      = accept && isObj && pixX >= x0 && pixX <= x1 && pixY >= y0 && pixY <= y1;
        nxt.xMin = (hit && pixX < base.xMin) ? pixX : base.xMin;
        nxt.xMax = (hit && pixX > base.xMax) ? pixX : base.xMax;
        nxt.yMin = (hit && pixY < base.yMin) ? pixY : base.yMin;
        nxt.yMax = (hit && pixY > base.yMax) ? pixY : base.yMax;
        nxtCnt   = (hit && !(&baseCnt)) ? baseCnt + 1'b1 : baseCnt;
        nxtFound = nxtCnt != '0;
    end
    // Results are captured from the final pixel's accumulator update so they appear in the PUBLISH cycle
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state       <= WAIT_SOF;
            thrSh       <= '0;
            x0Sh        <= '0;
            x1Sh        <= '0;
            y0Sh        <= '0;
            y1Sh        <= '0;
            acc         <= BBOX_CLR;
            cnt         <= '0;
            bus.oXSTART <= '0;
            bus.oXEND   <= '0;
            bus.oYSTART <= '0;
            bus.oYEND   <= '0;
            bus.oCOUNT  <= '0;
            bus.oFOUND  <= 1'b0;
            bus.oVALID  <= 1'b0;
        end else begin
            acc        <= nxt;
            cnt        <= nxtCnt;
            bus.oVALID <= last;
            if (bus.iSOF) begin
                thrSh <= bus.iTHRESH;
                x0Sh  <= bus.iROI_X0;
                x1Sh  <= bus.iROI_X1;
                y0Sh  <= bus.iROI_Y0;
                y1Sh  <= bus.iROI_Y1;
            end
            if (last) begin
                bus.oXSTART <= nxtFound ? nxt.xMin : '0;
                bus.oXEND   <= nxtFound ? nxt.xMax : '0;
                bus.oYSTART <= nxtFound ? nxt.yMin : '0;
                bus.oYEND   <= nxtFound ? nxt.yMax : '0;
                bus.oCOUNT  <= nxtCnt;
                bus.oFOUND  <= nxtFound;
            end
            state <= last ? PUBLISH : bus.iSOF ? ACCUM : state == PUBLISH ? WAIT_SOF : state;
        end
    end
endmodule
